// File: rtl/requant_pkg.sv
// requant_pkg: shared widths, types and helpers for the int32 -> uint8
// requantization pipeline.
//   ACC_W   : accumulator / bias width (signed)
//   MULT_W  : unsigned requant multiplier width
//   SHIFT_W : right-shift amount width (0..31)
//   PROD_W  : signed product width, wide enough for acc * zero-extended mult
package requant_pkg;

  localparam int ACC_W   = 32;
  localparam int MULT_W  = 16;
  localparam int SHIFT_W = 5;
  localparam int PROD_W  = ACC_W + MULT_W + 1;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef struct packed {
    acc_t               bias;
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
    logic [7:0]         zp;
  } requant_cfg_t;

  typedef struct packed {
    acc_t sum;
    logic sat;
  } sat_sum_t;

  // Identity configuration: bias 0, mult 1, shift 0, zero point 0.
  localparam requant_cfg_t CFG_IDENTITY = '{
    bias:  '0,
    mult:  MULT_W'(1),
    shift: '0,
    zp:    '0
  };

  // Signed add with one guard bit; on overflow the result pins to the
  // signed extreme in the direction of the true sum.
  function automatic sat_sum_t sat_add32(input acc_t a, input acc_t b);
    logic [ACC_W:0] wide;
    sat_sum_t       res;
    wide    = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    res.sat = wide[ACC_W] ^ wide[ACC_W-1];
    if (res.sat) begin
      res.sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      res.sum = wide[ACC_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/round_shift_clamp_u8.sv
// round_shift_clamp_u8: final requant stage, purely combinational.
//   prod   : signed scaled product
//   shift  : arithmetic right-shift amount
//   zp     : output zero point added after the shift
//   sat_in : saturation already flagged upstream for this item
//   data   : result clamped to [0,255]
//   sat    : clamp occurred or sat_in
// Build option REQUANT_ROUND_EN: when defined, round half up by adding
// 1 << (shift-1) before shifting (nothing added for shift 0); otherwise the
// shift truncates toward minus infinity and no rounding adder exists.
module round_shift_clamp_u8
  import requant_pkg::*;
(
  input  logic signed [PROD_W-1:0]  prod,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic        [7:0]         zp,
  input  logic                      sat_in,
  output logic        [7:0]         data,
  output logic                      sat
);

  prod_t rounded;
  prod_t shifted;
  prod_t r;
  logic  clamp;

  always_comb begin
    rounded = prod;
`ifdef REQUANT_ROUND_EN
    if (shift != '0) begin
      rounded = prod + (prod_t'(1) <<< (shift - SHIFT_W'(1)));
    end
`endif
    shifted = rounded >>> shift;
    r       = shifted + $signed({{(PROD_W-8){1'b0}}, zp});
    clamp   = 1'b0;
    data    = r[7:0];
    if (r[PROD_W-1]) begin
      data  = 8'd0;
      clamp = 1'b1;
    end else if (|r[PROD_W-2:8]) begin
      data  = 8'd255;
      clamp = 1'b1;
    end
    sat = sat_in | clamp;
  end

endmodule

// File: rtl/requant_int32_uint8.sv
// requant_int32_uint8: converts signed int32 accumulators to uint8
// activations through a three-stage pipeline:
//   S1 bias add (saturating) -> S2 scale multiply -> S3 shift/zp/clamp.
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   acc_in/in_valid/in_ready        : accumulator input handshake
//   out_data/out_sat/out_valid/out_ready : uint8 result handshake
//   cfg_we + cfg_bias/mult/shift/zp : configuration load, only taken when
//                                     the pipeline is empty and no input
//                                     is offered
//   cfg_err               : one-cycle pulse when a cfg_we was rejected
// Build option REQUANT_ROUND_EN selects round-half-up in S3 (see
// round_shift_clamp_u8); handshake and latency are the same either way.
module requant_int32_uint8
  import requant_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [ACC_W-1:0]   acc_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic        [7:0]         out_data,
  output logic                      out_sat,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      cfg_we,
  input  logic signed [ACC_W-1:0]   cfg_bias,
  input  logic        [MULT_W-1:0]  cfg_mult,
  input  logic        [SHIFT_W-1:0] cfg_shift,
  input  logic        [7:0]         cfg_zp,
  output logic                      cfg_err
);

  requant_cfg_t cfg_q, cfg_d;
  logic         cfg_err_q, cfg_err_d;

  logic         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  acc_t         s1_q, s1_d;
  logic         sat1_q, sat1_d;
  prod_t        p2_q, p2_d;
  logic         sat2_q, sat2_d;
  logic [7:0]   data3_q, data3_d;
  logic         sat3_q, sat3_d;

  logic         en1, en2, en3;
  logic         idle;
  sat_sum_t     s1_sum;
  logic [7:0]   rsc_data;
  logic         rsc_sat;

  // A stage loads when it is empty or its contents move on this cycle;
  // chained combinationally so a full pipe streams without bubbles.
  assign en3      = !v3_q || out_ready;
  assign en2      = !v2_q || en3;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;
  assign idle     = !v1_q && !v2_q && !v3_q && !in_valid;

  round_shift_clamp_u8 u_rsc (
    .prod   (p2_q),
    .shift  (cfg_q.shift),
    .zp     (cfg_q.zp),
    .sat_in (sat2_q),
    .data   (rsc_data),
    .sat    (rsc_sat)
  );

  always_comb begin
    s1_sum  = sat_add32(acc_in, cfg_q.bias);

    v1_d    = en1 ? in_valid : v1_q;
    s1_d    = s1_q;
    sat1_d  = sat1_q;
    if (en1 && in_valid) begin
      s1_d   = s1_sum.sum;
      sat1_d = s1_sum.sat;
    end

    v2_d    = en2 ? v1_q : v2_q;
    p2_d    = p2_q;
    sat2_d  = sat2_q;
    if (en2 && v1_q) begin
      p2_d   = prod_t'(s1_q) * prod_t'($signed({1'b0, cfg_q.mult}));
      sat2_d = sat1_q;
    end

    v3_d    = en3 ? v2_q : v3_q;
    data3_d = data3_q;
    sat3_d  = sat3_q;
    if (en3 && v2_q) begin
      data3_d = rsc_data;
      sat3_d  = rsc_sat;
    end

    // Config only changes with nothing in flight, so every item sees one
    // consistent configuration across all three stages.
    cfg_d     = cfg_q;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if (idle) begin
        cfg_d.bias  = cfg_bias;
        cfg_d.mult  = cfg_mult;
        cfg_d.shift = cfg_shift;
        cfg_d.zp    = cfg_zp;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg_q     <= CFG_IDENTITY;
      cfg_err_q <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_q      <= '0;
      sat1_q    <= 1'b0;
      p2_q      <= '0;
      sat2_q    <= 1'b0;
      data3_q   <= '0;
      sat3_q    <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      s1_q      <= s1_d;
      sat1_q    <= sat1_d;
      p2_q      <= p2_d;
      sat2_q    <= sat2_d;
      data3_q   <= data3_d;
      sat3_q    <= sat3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = data3_q;
  assign out_sat   = sat3_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_requant_int32_uint8.sv
module tb_requant_int32_uint8;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [31:0] acc_in;
  logic               in_valid;
  logic               in_ready;
  logic        [7:0] out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;
  logic               cfg_we;
  logic signed [31:0] cfg_bias;
  logic        [15:0] cfg_mult;
  logic        [4:0]  cfg_shift;
  logic        [7:0]  cfg_zp;
  logic               cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  requant_int32_uint8 dut (
    .clock     (clock),
    .reset     (reset),
    .acc_in    (acc_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_bias  (cfg_bias),
    .cfg_mult  (cfg_mult),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .cfg_err   (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Loads a configuration into an empty pipe; err_seen is cfg_err one cycle later.
  task automatic do_cfg(input logic signed [31:0] b, input logic [15:0] m,
                        input logic [4:0] s, input logic [7:0] z, output logic err_seen);
    cfg_bias = b; cfg_mult = m; cfg_shift = s; cfg_zp = z;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    err_seen = cfg_err;
    step();
  endtask

  // Sends one item into an empty pipe, waits (bounded) for its result.
  // lat counts clock edges from the accepting edge to out_valid.
  task automatic run_one(input logic signed [31:0] a, output logic [7:0] d,
                         output logic s, output int lat);
    acc_in = a; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    d = out_data;
    s = out_sat;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; acc_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_bias = '0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_checks++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got %0b exp 0", out_sat); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %0b exp 0", cfg_err); end
    step(); step();
    reset = 1'b0;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_identity();
    logic [7:0] d; logic s; int lat;
    run_one(50, d, s, lat);
    n_checks++; if (d !== 8'd50) begin n_fail++; $display("FAIL ident_50_data got %0d exp 50", d); end
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL ident_50_sat got %0b exp 0", s); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL ident_latency got %0d exp 3", lat); end
    run_one(300, d, s, lat);
    n_checks++; if (d !== 8'd255 || s !== 1'b1) begin n_fail++; $display("FAIL ident_300 got %0d/%0b exp 255/1", d, s); end
    run_one(-5, d, s, lat);
    n_checks++; if (d !== 8'd0 || s !== 1'b1) begin n_fail++; $display("FAIL ident_neg5 got %0d/%0b exp 0/1", d, s); end
  endtask

  task automatic test_rounding();
    logic [7:0] d; logic s; int lat; logic e; logic [7:0] exp_d;
    do_cfg(0, 16'd1, 5'd8, 8'd0, e);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL cfg_idle_no_err got %0b exp 0", e); end
`ifdef REQUANT_ROUND_EN
    exp_d = 8'd2;
`else
    exp_d = 8'd1;
`endif
    run_one(384, d, s, lat);
    n_checks++; if (d !== exp_d || s !== 1'b0) begin n_fail++; $display("FAIL round_384 got %0d/%0b exp %0d/0", d, s, exp_d); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL round_latency got %0d exp 3", lat); end
    run_one(65025, d, s, lat);
    n_checks++; if (d !== 8'd254 || s !== 1'b0) begin n_fail++; $display("FAIL round_65025 got %0d/%0b exp 254/0", d, s); end
  endtask

  task automatic test_clamp();
    logic [7:0] d; logic s; int lat; logic e;
    do_cfg(0, 16'd1, 5'd4, 8'd10, e);
    run_one(-1000, d, s, lat);
    n_checks++; if (d !== 8'd0 || s !== 1'b1) begin n_fail++; $display("FAIL clamp_low got %0d/%0b exp 0/1", d, s); end
    do_cfg(0, 16'd1, 5'd12, 8'd10, e);
    run_one(1600000, d, s, lat);
    n_checks++; if (d !== 8'd255 || s !== 1'b1) begin n_fail++; $display("FAIL clamp_high got %0d/%0b exp 255/1", d, s); end
    // (10+2)*3 = 36, >>2 = 9 (exact in both builds), +5 = 14
    do_cfg(2, 16'd3, 5'd2, 8'd5, e);
    run_one(10, d, s, lat);
    n_checks++; if (d !== 8'd14 || s !== 1'b0) begin n_fail++; $display("FAIL scale_mid got %0d/%0b exp 14/0", d, s); end
  endtask

  task automatic test_bias_sat();
    logic [7:0] d; logic s; int lat; logic e; logic [7:0] exp_d;
    do_cfg(32'sh100, 16'd1, 5'd31, 8'd0, e);
`ifdef REQUANT_ROUND_EN
    exp_d = 8'd1;
`else
    exp_d = 8'd0;
`endif
    run_one(32'sh7FFFFFF0, d, s, lat);
    n_checks++; if (d !== exp_d || s !== 1'b1) begin n_fail++; $display("FAIL bias_sat_pos got %0d/%0b exp %0d/1", d, s, exp_d); end
    // Negative overflow pins to -2^31; after shift 31 it is -1 either way, clamped to 0.
    do_cfg(-256, 16'd1, 5'd31, 8'd0, e);
    run_one(32'sh80000010, d, s, lat);
    n_checks++; if (d !== 8'd0 || s !== 1'b1) begin n_fail++; $display("FAIL bias_sat_neg got %0d/%0b exp 0/1", d, s); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [5];
    int idx; int n_out; int got [5]; int got_cyc [5]; logic acc_ok; logic e;
    vals = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    idx = 0; n_out = 0;
    do_cfg(0, 16'd1, 5'd0, 8'd0, e);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 5);
      acc_in   = (idx < 5) ? 32'(vals[idx]) : 32'sd0;
      #1;
      acc_ok = in_valid && in_ready;
      step();
      if (acc_ok) idx++;
    end
    n_checks++; if (idx != 3) begin n_fail++; $display("FAIL bp_accepts got %0d exp 3", idx); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %0b exp 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd5) begin n_fail++; $display("FAIL bp_hold got %0b/%0d exp 1/5", out_valid, out_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n_out < 5; c++) begin
      in_valid = (idx < 5);
      acc_in   = (idx < 5) ? 32'(vals[idx]) : 32'sd0;
      #1;
      acc_ok = in_valid && in_ready;
      if (out_valid) begin
        got[n_out] = out_data;
        got_cyc[n_out] = c;
        n_out++;
      end
      step();
      if (acc_ok) idx++;
    end
    in_valid = 1'b0;
    n_checks++; if (n_out != 5) begin n_fail++; $display("FAIL bp_count got %0d exp 5", n_out); end
    for (int i = 0; i < n_out; i++) begin
      n_checks++; if (got[i] != 5 + i) begin n_fail++; $display("FAIL bp_order[%0d] got %0d exp %0d", i, got[i], 5 + i); end
      if (i > 0) begin
        n_checks++; if (got_cyc[i] != got_cyc[i-1] + 1) begin n_fail++; $display("FAIL bp_rate[%0d] got cycle %0d exp %0d", i, got_cyc[i], got_cyc[i-1] + 1); end
      end
    end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %0b exp 0", out_valid); end
  endtask

  task automatic test_cfg_err();
    logic [7:0] d; logic s; int lat;
    out_ready = 1'b1;
    acc_in = 20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    cfg_bias = 100; cfg_mult = 16'd7; cfg_shift = 5'd3; cfg_zp = 8'd9;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_pulse got %0b exp 1", cfg_err); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd20) begin n_fail++; $display("FAIL cfg_err_inflight got %0b/%0d exp 1/20", out_valid, out_data); end
    step();
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_width got %0b exp 0", cfg_err); end
    run_one(30, d, s, lat);
    n_checks++; if (d !== 8'd30 || s !== 1'b0) begin n_fail++; $display("FAIL cfg_err_kept_cfg got %0d/%0b exp 30/0", d, s); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d; logic s; int lat; logic e; logic stale;
    do_cfg(0, 16'd2, 5'd0, 8'd5, e);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc_in = 40 + i; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'd85) begin n_fail++; $display("FAIL arst_pre got %0b/%0d exp 1/85", out_valid, out_data); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_full got %0b exp 0", in_ready); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_async got %0b exp 0", out_valid); end
    step(); step();
    reset = 1'b0;
    n_checks++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL arst_data got %0d exp 0", out_data); end
    out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) stale = 1'b1;
      step();
    end
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL arst_stale got %0b exp 0", stale); end
    run_one(100, d, s, lat);
    n_checks++; if (d !== 8'd100 || s !== 1'b0) begin n_fail++; $display("FAIL arst_identity got %0d/%0b exp 100/0", d, s); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL arst_latency got %0d exp 3", lat); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rounding();
    test_clamp();
    test_bias_sat();
    test_back_to_back();
    test_cfg_err();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
